// File: rtl/weigh_pkg.sv
// -----------------------------------------------------------------------------
// weigh_pkg
// Shared definitions for the load-cell weighing sequencer:
//   - sequencer state encoding
//   - raw sample / accumulator / net result widths
//   - saturation limits and the 34-bit to 32-bit saturating helper
// No ports (package).
// -----------------------------------------------------------------------------
package weigh_pkg;

   localparam int RAW_W        = 24;                  // converter code width
   localparam int NET_W        = 32;                  // net weight width
   localparam int AVG_LOG2_DEF = 3;                   // default window = 8 samples
   localparam int ACC_W        = RAW_W + AVG_LOG2_DEF; // accumulator width for default window
   localparam int DIFF_W       = RAW_W + 1;           // avg - tare / avg - prev_avg
   localparam int PROD_W       = 34;                  // difference * gram scale

   localparam logic signed [NET_W-1:0]  NET_MAX      = 32'sh7FFF_FFFF;
   localparam logic signed [NET_W-1:0]  NET_MIN      = 32'sh8000_0000;
   localparam logic signed [PROD_W-1:0] PROD_POS_LIM = 34'sh0_7FFF_FFFF;
   localparam logic signed [PROD_W-1:0] PROD_NEG_LIM = 34'sh3_8000_0000; // -2^31

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_TARE_ACC = 3'd1,
      ST_MEAS_ACC = 3'd2,
      ST_REPORT   = 3'd3,
      ST_ERROR    = 3'd4
   } state_e;

   // Clamp a signed product into the signed 32-bit result range.
   function automatic logic signed [NET_W-1:0] sat_net(input logic signed [PROD_W-1:0] p);
      logic signed [NET_W-1:0] r;
      if (p > PROD_POS_LIM) begin
         r = NET_MAX;
      end else if (p < PROD_NEG_LIM) begin
         r = NET_MIN;
      end else begin
         r = p[NET_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/weigh_avg_acc.sv
// -----------------------------------------------------------------------------
// weigh_avg_acc
// Block averager: sums 2^AVG_LOG2 signed samples and reports the arithmetic
// mean together with a done pulse in the same cycle as the last sample, so the
// caller can register the result on that edge.
// Ports:
//   clk_50    in   system clock
//   rst_n     in   synchronous active-low reset
//   clr_i     in   discard partial window (dominates en_i)
//   en_i      in   accept sample_i into the window
//   sample_i  in   signed raw sample
//   avg_o     out  window mean, valid when done_o=1
//   done_o    out  current sample completes the window
// -----------------------------------------------------------------------------
module weigh_avg_acc
   import weigh_pkg::*;
#(
   parameter int AVG_LOG2 = 3
) (
   input  logic                    clk_50,
   input  logic                    rst_n,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic signed [RAW_W-1:0] sample_i,
   output logic signed [RAW_W-1:0] avg_o,
   output logic                    done_o
);

   localparam int AW = RAW_W + AVG_LOG2;

   logic signed [AW-1:0]    acc_q, acc_d;
   logic signed [AW-1:0]    sum_s;
   logic signed [AW-1:0]    shr_s;
   logic [AVG_LOG2-1:0]     cnt_q, cnt_d;

   // Running sum including the current sample; window restarts after done.
   always_comb begin
      sum_s  = acc_q + {{AVG_LOG2{sample_i[RAW_W-1]}}, sample_i};
      shr_s  = sum_s >>> AVG_LOG2;
      avg_o  = shr_s[RAW_W-1:0];
      done_o = en_i && (cnt_q == {AVG_LOG2{1'b1}});
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (done_o) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (en_i) begin
         acc_d = sum_s;
         cnt_d = cnt_q + AVG_LOG2'(1);
      end else begin
         acc_d = acc_q;
         cnt_d = cnt_q;
      end
   end

   // Accumulator and sample-count registers.
   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/weigh_seq_ctrl.sv
// -----------------------------------------------------------------------------
// weigh_seq_ctrl
// Turns the converter sample stream into tare-corrected, gram-scaled weight
// results with a stability flag, offered on a valid/ready handshake.
// Optional build macro: WEIGH_AUTO_ZERO_EN (auto-zero tracking of tare when a
// stable reading lies within ZERO_BAND of the current tare).
// Ports:
//   clk_50        in   50 MHz system clock
//   rst_n         in   synchronous active-low reset
//   sample_valid  in   converter frame pulse
//   sample_raw    in   24-bit signed raw code
//   tare_req      in   tare capture request pulse
//   meas_en       in   continuous measurement enable
//   weight_net    out  saturated (avg - tare) * GRAM_SCALE
//   weight_valid  out  result valid
//   weight_ready  in   result accepted
//   stable        out  stability flag per completed window
//   tare_done     out  pulse after a tare capture
//   busy          out  accumulating or reporting
//   err_timeout   out  converter silent for TIMEOUT_CYC cycles
// -----------------------------------------------------------------------------
module weigh_seq_ctrl
   import weigh_pkg::*;
#(
   parameter int AVG_LOG2    = 3,
   parameter int STABLE_TH   = 200,
   parameter int STABLE_CNT  = 4,
   parameter int TIMEOUT_CYC = 5000000,
   parameter int GRAM_SCALE  = 182,
   parameter int ZERO_BAND   = 50
) (
   input  logic                    clk_50,
   input  logic                    rst_n,
   input  logic                    sample_valid,
   input  logic [RAW_W-1:0]        sample_raw,
   input  logic                    tare_req,
   input  logic                    meas_en,
   output logic signed [NET_W-1:0] weight_net,
   output logic                    weight_valid,
   input  logic                    weight_ready,
   output logic                    stable,
   output logic                    tare_done,
   output logic                    busy,
   output logic                    err_timeout
);

   localparam int SC_W  = $clog2(STABLE_CNT + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [SC_W-1:0]          STAB_MAX = SC_W'(STABLE_CNT);
   localparam logic [TMO_W-1:0]         TMO_LIM  = TMO_W'(TIMEOUT_CYC);
   localparam logic [DIFF_W-1:0]        TH_C     = DIFF_W'(STABLE_TH);
   localparam logic signed [PROD_W-1:0] SCALE_C  = PROD_W'(GRAM_SCALE);

   state_e                  state_q, state_d;
   logic signed [RAW_W-1:0] tare_q, tare_d;
   logic signed [RAW_W-1:0] prev_q, prev_d;
   logic [SC_W-1:0]         stab_q, stab_d;
   logic                    first_q, first_d;
   logic                    pend_q, pend_d;
   logic [TMO_W-1:0]        tmo_q, tmo_d;
   logic signed [NET_W-1:0] net_q, net_d;
   logic                    stable_q, stable_d;
   logic                    tdone_q, tdone_d;
   logic                    valid_q, busy_q, err_q;

   logic                     acc_clr_s, acc_en_s, acc_done_s;
   logic signed [RAW_W-1:0]  acc_avg_s;
   logic signed [DIFF_W-1:0] avg_ext_s, diff_s, delta_s;
   logic [DIFF_W-1:0]        delta_abs_s;
   logic signed [PROD_W-1:0] diff_x_s, prod_s;
   logic [SC_W-1:0]          stab_new_s;
   logic [TMO_W-1:0]         tmo_inc_s;

   weigh_avg_acc #(
      .AVG_LOG2 (AVG_LOG2)
   ) u_avg (
      .clk_50   (clk_50),
      .rst_n    (rst_n),
      .clr_i    (acc_clr_s),
      .en_i     (acc_en_s),
      .sample_i (sample_raw),
      .avg_o    (acc_avg_s),
      .done_o   (acc_done_s)
   );

`ifdef WEIGH_AUTO_ZERO_EN
   localparam logic [DIFF_W-1:0] ZB_C = DIFF_W'(ZERO_BAND);
   logic [DIFF_W-1:0] zabs_s;

   // Distance of the fresh average from the current tare.
   always_comb begin
      zabs_s = diff_s[DIFF_W-1] ? DIFF_W'(-diff_s) : DIFF_W'(diff_s);
   end
`endif

   // Window arithmetic: net product, stability distance, stability count.
   always_comb begin
      avg_ext_s   = {acc_avg_s[RAW_W-1], acc_avg_s};
      diff_s      = avg_ext_s - {tare_q[RAW_W-1], tare_q};
      diff_x_s    = {{(PROD_W-DIFF_W){diff_s[DIFF_W-1]}}, diff_s};
      prod_s      = diff_x_s * SCALE_C;
      delta_s     = avg_ext_s - {prev_q[RAW_W-1], prev_q};
      delta_abs_s = delta_s[DIFF_W-1] ? DIFF_W'(-delta_s) : DIFF_W'(delta_s);
      tmo_inc_s   = sample_valid ? '0 : (tmo_q + TMO_W'(1));
      if (first_q) begin
         stab_new_s = '0;
      end else if (delta_abs_s <= TH_C) begin
         stab_new_s = (stab_q == STAB_MAX) ? stab_q : (stab_q + SC_W'(1));
      end else begin
         stab_new_s = '0;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d   = state_q;
      tare_d    = tare_q;
      prev_d    = prev_q;
      stab_d    = stab_q;
      first_d   = first_q;
      pend_d    = pend_q;
      net_d     = net_q;
      stable_d  = stable_q;
      tdone_d   = 1'b0;
      tmo_d     = '0;
      acc_clr_s = 1'b1;
      acc_en_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tare_req) begin
               state_d = ST_TARE_ACC;
            end else if (meas_en) begin
               state_d = ST_MEAS_ACC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_TARE_ACC: begin
            acc_clr_s = 1'b0;
            acc_en_s  = sample_valid;
            tmo_d     = tmo_inc_s;
            if (acc_done_s) begin
               tare_d  = acc_avg_s;
               tdone_d = 1'b1;
               stab_d  = '0;
               first_d = 1'b1;
               state_d = meas_en ? ST_MEAS_ACC : ST_IDLE;
            end else if (tmo_inc_s == TMO_LIM) begin
               state_d = ST_ERROR;
            end else begin
               state_d = ST_TARE_ACC;
            end
         end
         ST_MEAS_ACC: begin
            // A tare request wins over a coincident sample, which is dropped.
            acc_clr_s = tare_req;
            acc_en_s  = sample_valid && !tare_req && meas_en;
            tmo_d     = tmo_inc_s;
            if (tare_req) begin
               state_d = ST_TARE_ACC;
            end else if (!meas_en) begin
               first_d = 1'b1;
               state_d = ST_IDLE;
            end else if (acc_done_s) begin
               net_d    = sat_net(prod_s);
               stab_d   = stab_new_s;
               first_d  = 1'b0;
               prev_d   = acc_avg_s;
               stable_d = (stab_new_s == STAB_MAX);
               state_d  = ST_REPORT;
`ifdef WEIGH_AUTO_ZERO_EN
               if ((stab_new_s == STAB_MAX) && (zabs_s <= ZB_C)) begin
                  tare_d = acc_avg_s;
               end else begin
                  tare_d = tare_q;
               end
`endif
            end else if (tmo_inc_s == TMO_LIM) begin
               state_d = ST_ERROR;
            end else begin
               state_d = ST_MEAS_ACC;
            end
         end
         ST_REPORT: begin
            if (tare_req) begin
               pend_d = 1'b1;
            end else begin
               pend_d = pend_q;
            end
            if (weight_ready) begin
               if (pend_q || tare_req) begin
                  state_d = ST_TARE_ACC;
               end else if (meas_en) begin
                  state_d = ST_MEAS_ACC;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_REPORT;
            end
         end
         ST_ERROR: begin
            if (tare_req) begin
               state_d = ST_TARE_ACC;
            end else if (!meas_en) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ERROR;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Fresh timeout window on every state change; pending tare consumed on entry.
      if (state_d != state_q) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_d;
      end
      if ((state_d == ST_TARE_ACC) && (state_q != ST_TARE_ACC)) begin
         pend_d = 1'b0;
      end else begin
         pend_d = pend_d;
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         tare_q   <= '0;
         prev_q   <= '0;
         stab_q   <= '0;
         first_q  <= 1'b1;
         pend_q   <= 1'b0;
         tmo_q    <= '0;
         net_q    <= '0;
         stable_q <= 1'b0;
         tdone_q  <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tare_q   <= tare_d;
         prev_q   <= prev_d;
         stab_q   <= stab_d;
         first_q  <= first_d;
         pend_q   <= pend_d;
         tmo_q    <= tmo_d;
         net_q    <= net_d;
         stable_q <= stable_d;
         tdone_q  <= tdone_d;
         valid_q  <= (state_d == ST_REPORT);
         busy_q   <= (state_d == ST_TARE_ACC) || (state_d == ST_MEAS_ACC) ||
                     (state_d == ST_REPORT);
         err_q    <= (state_d == ST_ERROR);
      end
   end

   assign weight_net   = net_q;
   assign weight_valid = valid_q;
   assign stable       = stable_q;
   assign tare_done    = tdone_q;
   assign busy         = busy_q;
   assign err_timeout  = err_q;

endmodule

// File: tb/tb_weigh_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_weigh_seq_ctrl
// Directed bench for weigh_seq_ctrl with a behavioural reference model
// (sample queues and integer arithmetic) compared every cycle, plus literal
// expectations at key points of the scenario.
// -----------------------------------------------------------------------------
module tb_weigh_seq_ctrl;

   localparam int TMO = 1000;
   localparam int M_IDLE = 0, M_TARE = 1, M_MEAS = 2, M_REP = 3, M_ERR = 4;

   logic               clk_50 = 1'b0;
   logic               rst_n = 1'b0;
   logic               sample_valid = 1'b0;
   logic [23:0]        sample_raw = 24'h0;
   logic               tare_req = 1'b0;
   logic               meas_en = 1'b0;
   logic               weight_ready = 1'b0;
   logic signed [31:0] weight_net;
   logic               weight_valid, stable, tare_done, busy, err_timeout;

   int checks = 0;
   int errors = 0;
   int td_cnt = 0;

   // reference model state
   int          m_mode = M_IDLE;
   longint      m_q[$];
   longint      m_tare = 0, m_prev = 0;
   int          m_stab = 0, m_tmo = 0;
   bit          m_first = 1'b1, m_pend = 1'b0;
   logic [31:0] e_net = 32'h0;
   bit          e_stable = 1'b0, e_td = 1'b0;
   bit          cmp_on = 1'b0;

   always #5 clk_50 = ~clk_50;

   weigh_seq_ctrl #(.TIMEOUT_CYC(TMO)) dut (
      .clk_50       (clk_50),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .sample_raw   (sample_raw),
      .tare_req     (tare_req),
      .meas_en      (meas_en),
      .weight_net   (weight_net),
      .weight_valid (weight_valid),
      .weight_ready (weight_ready),
      .stable       (stable),
      .tare_done    (tare_done),
      .busy         (busy),
      .err_timeout  (err_timeout)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint win_avg();
      longint s = 0;
      foreach (m_q[i]) s += m_q[i];
      return s >>> 3;
   endfunction

   function automatic logic [31:0] sat32(input longint v);
      logic [63:0] t;
      if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
      if (v < -64'sd2147483648) return 32'h8000_0000;
      t = v;
      return t[31:0];
   endfunction

   task automatic go_tare();
      m_mode = M_TARE; m_q.delete(); m_pend = 1'b0; m_tmo = 0;
   endtask

   task automatic go_meas();
      m_mode = M_MEAS; m_q.delete(); m_tmo = 0;
   endtask

   task automatic count_silence();
      m_tmo = sample_valid ? 0 : m_tmo + 1;
      if (m_tmo == TMO) m_mode = M_ERR;
   endtask

   task automatic finish_meas();
      longint avg, d;
      avg = win_avg();
      m_q.delete();
      e_net = sat32((avg - m_tare) * 182);
      d = (avg > m_prev) ? avg - m_prev : m_prev - avg;
      if (m_first) begin
         m_stab = 0; m_first = 1'b0;
      end else if (d <= 200) begin
         m_stab = (m_stab < 4) ? m_stab + 1 : 4;
      end else begin
         m_stab = 0;
      end
      m_prev = avg;
      e_stable = (m_stab == 4);
      m_mode = M_REP;
   endtask

   // One model step: inputs present now are those the DUT sees at the next edge.
   task automatic model_step();
      e_td = 1'b0;
      if (!rst_n) begin
         m_mode = M_IDLE; m_q.delete(); m_tare = 0; m_prev = 0; m_stab = 0;
         m_first = 1'b1; m_pend = 1'b0; m_tmo = 0; e_net = 32'h0; e_stable = 1'b0;
      end else begin
         case (m_mode)
            M_IDLE: if (tare_req) go_tare(); else if (meas_en) go_meas();
            M_TARE: begin
               if (sample_valid) m_q.push_back(longint'($signed(sample_raw)));
               if (m_q.size() == 8) begin
                  m_tare = win_avg(); m_q.delete(); e_td = 1'b1; m_stab = 0; m_first = 1'b1;
                  if (meas_en) go_meas(); else m_mode = M_IDLE;
               end else count_silence();
            end
            M_MEAS: begin
               if (tare_req) go_tare();
               else if (!meas_en) begin m_mode = M_IDLE; m_first = 1'b1; end
               else begin
                  if (sample_valid) m_q.push_back(longint'($signed(sample_raw)));
                  if (m_q.size() == 8) finish_meas(); else count_silence();
               end
            end
            M_REP: begin
               if (tare_req) m_pend = 1'b1;
               if (weight_ready) begin
                  if (m_pend) go_tare(); else if (meas_en) go_meas(); else m_mode = M_IDLE;
               end
            end
            M_ERR: if (tare_req) go_tare(); else if (!meas_en) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
         endcase
      end
   endtask

   // Compare DUT against the model every cycle, then advance the model.
   always @(negedge clk_50) begin
      if (cmp_on) begin
         chk("m_net", weight_net, e_net);
         chk("m_valid", {31'd0, weight_valid}, {31'd0, m_mode == M_REP});
         chk("m_stable", {31'd0, stable}, {31'd0, e_stable});
         chk("m_tare_done", {31'd0, tare_done}, {31'd0, e_td});
         chk("m_busy", {31'd0, busy}, {31'd0, (m_mode >= M_TARE) && (m_mode <= M_REP)});
         chk("m_err", {31'd0, err_timeout}, {31'd0, m_mode == M_ERR});
         if (tare_done === 1'b1) td_cnt++;
      end
      model_step();
      cmp_on = 1'b1;
   end

   task automatic tick();
      @(posedge clk_50);
      #2;
   endtask

   task automatic send(input logic [23:0] v);
      sample_valid = 1'b1; sample_raw = v;
      tick();
      sample_valid = 1'b0;
      tick();
   endtask

   task automatic window(input logic [23:0] v);
      for (int i = 0; i < 8; i++) send(v);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (weight_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk(name, {31'd0, weight_valid}, 32'd1);
   endtask

   task automatic ack();
      weight_ready = 1'b1;
      tick();
      weight_ready = 1'b0;
   endtask

   bit exp_st[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   int n_tmo;

   initial begin
      repeat (3) tick();
      chk("rst_valid", {31'd0, weight_valid}, 32'd0);
      chk("rst_net", weight_net, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      tick();

      // 1: tare with measurement disabled
      tare_req = 1'b1; tick(); tare_req = 1'b0;
      window(24'h000100);
      chk("t1_tare_done_once", td_cnt, 32'd1);
      chk("t1_idle", {31'd0, busy}, 32'd0);

      // 2: first measurement, latency and hold
      meas_en = 1'b1; tick();
      for (int i = 0; i < 7; i++) send(24'h000200);
      chk("t2_not_early", {31'd0, weight_valid}, 32'd0);
      sample_valid = 1'b1; sample_raw = 24'h000200;
      tick();
      sample_valid = 1'b0;
      chk("t2_valid_next", {31'd0, weight_valid}, 32'd1);
      chk("t2_net", weight_net, 32'd46592);
      repeat (5) tick();
      chk("t2_hold_valid", {31'd0, weight_valid}, 32'd1);
      chk("t2_hold_net", weight_net, 32'd46592);
      ack();

      // 3: stability over consecutive windows, then a jump
      for (int k = 0; k < 4; k++) begin
         window(24'h000200);
         wait_valid("t3_valid");
         chk("t3_stable", {31'd0, stable}, {31'd0, exp_st[k]});
         ack();
      end
      window(24'h000400);
      wait_valid("t3_jump_valid");
      chk("t3_jump_stable", {31'd0, stable}, 32'd0);
      chk("t3_jump_net", weight_net, 32'd139776);
      ack();

      // 4: back-pressure drops samples; next window needs 8 fresh samples
      window(24'h000200);
      wait_valid("t4_valid");
      for (int i = 0; i < 33; i++) begin
         send(24'h000300);
         tick();
      end
      chk("t4_held_net", weight_net, 32'd46592);
      chk("t4_held_valid", {31'd0, weight_valid}, 32'd1);
      ack();
      for (int i = 0; i < 7; i++) send(24'h000200);
      chk("t4_no_early", {31'd0, weight_valid}, 32'd0);
      send(24'h000200);
      chk("t4_fresh_valid", {31'd0, weight_valid}, 32'd1);
      chk("t4_fresh_net", weight_net, 32'd46592);
      ack();

      // 5: converter silence -> timeout error, cleared by dropping meas_en
      n_tmo = 0;
      while (err_timeout !== 1'b1 && n_tmo < 1100) begin
         tick();
         n_tmo++;
      end
      chk("t5_tmo_in_window", {31'd0, (n_tmo >= 990) && (n_tmo <= 1010)}, 32'd1);
      chk("t5_err", {31'd0, err_timeout}, 32'd1);
      meas_en = 1'b0;
      tick(); tick();
      chk("t5_err_clear", {31'd0, err_timeout}, 32'd0);
      chk("t5_idle", {31'd0, busy}, 32'd0);

      // 6: tare request over a coincident sample, negative saturation, reset mid-window
      meas_en = 1'b1; tick();
      for (int i = 0; i < 3; i++) send(24'h000005);
      tare_req = 1'b1; sample_valid = 1'b1; sample_raw = 24'h123456;
      tick();
      tare_req = 1'b0; sample_valid = 1'b0;
      tick();
      window(24'h7FFFFF);
      chk("t6_tare_done", td_cnt, 32'd2);
      chk("t6_meas_busy", {31'd0, busy}, 32'd1);
      window(24'h800000);
      wait_valid("t6_valid");
      chk("t6_sat_net", weight_net, 32'h8000_0000);
      ack();
      for (int i = 0; i < 3; i++) send(24'h7FFFFF);
      rst_n = 1'b0;
      tick();
      chk("t6_rst_valid", {31'd0, weight_valid}, 32'd0);
      chk("t6_rst_net", weight_net, 32'd0);
      chk("t6_rst_busy", {31'd0, busy}, 32'd0);
      chk("t6_rst_flags", {29'd0, stable, tare_done, err_timeout}, 32'd0);
      rst_n = 1'b1;
      tick(); tick();
      window(24'h000200);
      wait_valid("t6_post_rst_valid");
      chk("t6_post_rst_net", weight_net, 32'd93184);
      ack();
      meas_en = 1'b0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
